reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, cycles both resets stay asserted after release/trigger (min 1).
REQ-002 SHALL have parameter STAGGER_CYCLES, default 8, cycles between peripheral and CPU reset release (min 1).
REQ-003 SHALL have parameter WDT_CYCLES, default 1024, watchdog timeout in cycles (min 2; used only with watchdog).
REQ-004 clk_in  input  1  system clock (slow_clk domain); one clock.
REQ-005 reset_in  input  1  asynchronous, active-low reset (PLL locked qualified); may deassert asynchronously.
REQ-006 btn_press_in  input  1  one-cycle, clk_in-synchronous reset-button pulse from debouncer.
REQ-007 wdt_kick_in  input  1  watchdog kick, level sampled each cycle (present only with watchdog).
REQ-008 periph_reset_n_out  output  1  active-low peripheral/bus reset.
REQ-009 cpu_reset_n_out  output  1  active-low CPU core reset.
REQ-010 busy_out  output  1  high while any reset output is asserted.
REQ-011 cause_out  output  2  last reset cause: 00 power-on, 01 button, 10 watchdog, 11 unused.

Function
REQ-012 SHALL pass reset_in deassertion through an internal 2-flop synchronizer; assertion SHALL act asynchronously on all state.
REQ-013 SHALL implement states ASSERT, HOLD, STAGGER, RUN; all outputs registered.
REQ-014 ASSERT: both reset outputs low, busy_out high; leave to HOLD on first edge where synchronized reset is high, counter cleared.
REQ-015 HOLD: count HOLD_CYCLES cycles; on last one go to STAGGER and set periph_reset_n_out high on that same edge.
REQ-016 STAGGER: count STAGGER_CYCLES cycles; on last one go to RUN, set cpu_reset_n_out high and busy_out low on that same edge.
REQ-017 RUN: both resets high, busy_out low; remain until a trigger.
REQ-018 Power-on timing: counting the first clk_in edge with reset_in high as edge 1, periph_reset_n_out SHALL rise after edge 3+HOLD_CYCLES and cpu_reset_n_out after edge 3+HOLD_CYCLES+STAGGER_CYCLES.
REQ-019 btn_press_in high at edge k, in any state, SHALL force ASSERT with both resets low after edge k, cause_out=01; periph rises after edge k+1+HOLD_CYCLES.
REQ-020 A button pulse during HOLD or STAGGER SHALL restart the full sequence from ASSERT (counters cleared).
REQ-021 Button pulse and watchdog expiry on the same edge: button wins, cause_out=01.
REQ-022 cause_out SHALL change only on a new trigger and hold its value through the sequence and RUN.
REQ-023 Counters SHALL be $clog2-sized for their parameter and never wrap; they saturate/clear on state exit.
REQ-024 periph_reset_n_out SHALL never be high while cpu_reset_n_out is low-to-high ordering violated, i.e. CPU released never before peripherals.

Reset
REQ-025 reset_in low SHALL immediately force: state ASSERT, periph_reset_n_out=0, cpu_reset_n_out=0, busy_out=1, cause_out=00, all counters 0, synchronizer flops 0.
REQ-026 reset_in asserted mid-sequence or in RUN SHALL abort and restart from REQ-018 timing after release.

Configuration
REQ-027 Macro RESET_SEQ_WATCHDOG_EN: when defined, wdt_kick_in port and a watchdog counter exist; counter runs only in RUN, clears on wdt_kick_in high or outside RUN, and on reaching WDT_CYCLES-1 without a kick forces ASSERT next edge with cause_out=10.
REQ-028 Without RESET_SEQ_WATCHDOG_EN: no wdt_kick_in port, no watchdog logic, cause 10 never produced.

Verification
REQ-029 Defaults; release reset_in at edge 1 -> periph_reset_n_out high after edge 19, cpu_reset_n_out/busy_out low after edge 27, cause_out=00.
REQ-030 In RUN, btn_press_in pulse at edge 100 -> both resets low after edge 100, periph high after edge 117, cpu high after edge 125, cause_out=01.
REQ-031 Button pulse at edge 10 of HOLD then second pulse 5 cycles later -> release times measured from second pulse only.
REQ-032 reset_in pulled low asynchronously mid-STAGGER (between edges) -> all outputs reset-value immediately, cause_out=00, REQ-029 timing after release.
REQ-033 RESET_SEQ_WATCHDOG_EN, WDT_CYCLES=64: kick every 50 cycles -> no reset for 1000 cycles; stop kicking -> resets asserted 64 cycles after last kick, cause_out=10.
REQ-034 RESET_SEQ_WATCHDOG_EN: button pulse and watchdog expiry on same edge -> cause_out=01, single sequence.

Source files
------------

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Sequences system reset release. After reset_in deasserts, it is
//             synchronized, both reset outputs are held for HOLD_CYCLES, then
//             peripherals are released, and STAGGER_CYCLES later the CPU.
//             A button pulse (or, optionally, a watchdog expiry) restarts the
//             whole sequence. cause_out records the last reset cause.
//  Optional : RESET_SEQ_WATCHDOG_EN adds wdt_kick_in and a watchdog counter.
//  Ports    :
//    clk_in             in   system clock
//    reset_in           in   async active-low reset (PLL-lock qualified)
//    btn_press_in       in   one-cycle synchronous reset-button pulse
//    wdt_kick_in        in   watchdog kick (only with RESET_SEQ_WATCHDOG_EN)
//    periph_reset_n_out out  active-low peripheral/bus reset
//    cpu_reset_n_out    out  active-low CPU core reset
//    busy_out           out  high while any reset output is asserted
//    cause_out[1:0]     out  00 power-on, 01 button, 10 watchdog
//  Revision : 1.0  initial release
// ============================================================================
module reset_sequencer #(
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int WDT_CYCLES     = 1024
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       btn_press_in,
`ifdef RESET_SEQ_WATCHDOG_EN
  input  logic       wdt_kick_in,
`endif
  output logic       periph_reset_n_out,
  output logic       cpu_reset_n_out,
  output logic       busy_out,
  output logic [1:0] cause_out
);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_STAGGER = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int STAG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;

  // Elaboration-time guard on parameter ranges.
  if (HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 || WDT_CYCLES < 2) begin : g_param_check
    $error("reset_sequencer: parameter out of range");
  end

  logic              sync_meta;
  logic              sync_rst;
  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;
  logic [STAG_W-1:0] stag_cnt;
  logic [STAG_W-1:0] stag_cnt_nxt;
  logic              periph_nxt;
  logic              cpu_nxt;
  logic              busy_nxt;
  logic [1:0]        cause_nxt;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int               WDT_W      = $clog2(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_LAST   = WDT_W'(WDT_CYCLES - 1);
  localparam logic [1:0]       CAUSE_WDT  = 2'b10;

  logic [WDT_W-1:0] wdt_cnt;
  logic [WDT_W-1:0] wdt_cnt_nxt;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt_nxt;
    end
  end
`endif

  // Reset assertion is asynchronous; release ripples through two flops so
  // the sequence starts on a clean clock boundary.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      sync_meta          <= 1'b0;
      sync_rst           <= 1'b0;
      state              <= ST_ASSERT;
      hold_cnt           <= '0;
      stag_cnt           <= '0;
      periph_reset_n_out <= 1'b0;
      cpu_reset_n_out    <= 1'b0;
      busy_out           <= 1'b1;
      cause_out          <= CAUSE_POR;
    end else begin
      sync_meta          <= 1'b1;
      sync_rst           <= sync_meta;
      state              <= state_nxt;
      hold_cnt           <= hold_cnt_nxt;
      stag_cnt           <= stag_cnt_nxt;
      periph_reset_n_out <= periph_nxt;
      cpu_reset_n_out    <= cpu_nxt;
      busy_out           <= busy_nxt;
      cause_out          <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = '0;
    stag_cnt_nxt = '0;
    cause_nxt    = cause_out;

    case (state)
      ST_ASSERT: begin
        if (sync_rst) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nxt = ST_STAGGER;
        else                       hold_cnt_nxt = hold_cnt + 1'b1;
      end
      ST_STAGGER: begin
        if (stag_cnt == STAG_LAST) state_nxt = ST_RUN;
        else                       stag_cnt_nxt = stag_cnt + 1'b1;
      end
      default: ;  // ST_RUN: hold until a trigger
    endcase

`ifdef RESET_SEQ_WATCHDOG_EN
    // Counts unkicked RUN cycles; expiry restarts the sequence.
    wdt_cnt_nxt = '0;
    if (state == ST_RUN && !wdt_kick_in) begin
      if (wdt_cnt == WDT_LAST) begin
        state_nxt = ST_ASSERT;
        cause_nxt = CAUSE_WDT;
      end else begin
        wdt_cnt_nxt = wdt_cnt + 1'b1;
      end
    end
`endif

    // Button is applied last so it wins over a simultaneous watchdog expiry.
    if (btn_press_in) begin
      state_nxt    = ST_ASSERT;
      hold_cnt_nxt = '0;
      stag_cnt_nxt = '0;
      cause_nxt    = CAUSE_BTN;
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state transition while still coming straight from flops.
    periph_nxt = (state_nxt == ST_STAGGER) || (state_nxt == ST_RUN);
    cpu_nxt    = (state_nxt == ST_RUN);
    busy_nxt   = (state_nxt != ST_RUN);
  end

endmodule
`default_nettype wire
